dcache_dummy_readback: RTL and testbench
========================================

// Module: dcache_dummy_readback
// PURPOSE
//  Read-side counterpart of the ROM-to-DDR image loader: fetches image lines from DDR via the data-cache memory port.
//  Each 256-bit line holds 8 pixels, one byte in bits [7:0] of each 32-bit lane.
//  The block repacks each line into a 64-bit word and streams it to a consumer (NPU input / display) through a small FIFO.
//  Used to verify the loaded image and to feed it downstream.
// PARAMETERS
//  BASE_ADDR    28'h1000000  DDR address of first line
//  NUM_WORDS    38400        lines to read per run (1..65535)
//  ADDR_STRIDE  8            address increment per line
//  FIFO_DEPTH   2            output FIFO entries (power of 2, >=2)
// PORTS
//  clk              in   1    system clock
//  rst              in   1    synchronous active-high reset
//  start            in   1    1-cycle pulse: begin a run (ignored unless idle/done)
//  busy             out  1    run in progress
//  done             out  1    run complete and FIFO drained; held until next start
//  fmt_err          out  1    sticky: nonzero bits found in a lane's [31:8]
//  mem_data_addr1   out  28   DDR line address
//  mem_rw_data1     out  1    constant 0 (read only)
//  mem_valid_data1  out  1    request valid
//  mem_ready_data1  in   1    response ready; read data valid this cycle
//  mem_data_rd1     in   256  read data from DDR
//  mem_data_wr1     out  256  constant 0
//  out_data         out  64   packed pixel word (FIFO head)
//  out_valid        out  1    FIFO non-empty
//  out_ready        in   1    consumer accepts head when out_valid & out_ready
// BEHAVIOUR
//  Reset: all outputs 0 except mem_data_addr1=BASE_ADDR; FIFO emptied, line counter 0, FSM in IDLE.
//  FSM states:
//   IDLE  -> ISSUE on start; clears fmt_err, sets addr=BASE_ADDR, count=0.
//   ISSUE -> if FIFO occupancy < FIFO_DEPTH: assert mem_valid_data1 next cycle and go to WAIT; else stay.
//   WAIT  -> mem_valid_data1 held high, addr stable, until mem_ready_data1=1.
//            On that edge: capture, push to FIFO, drop valid, addr += ADDR_STRIDE, count++.
//            Then go to DRAIN if count==NUM_WORDS, else ISSUE.
//   DRAIN -> DONE when FIFO empty.
//   DONE  -> done=1; start re-enters ISSUE as from IDLE.
//  Request and response rules:
//   Only one request outstanding at a time.
//   mem_ready_data1 is ignored when mem_valid_data1=0.
//   Min 2 cycles between requests (valid low for at least 1 cycle).
//  Packing: out_data[8k+7:8k] = mem_data_rd1[32k+7:32k], k=0..7.
//   fmt_err |= OR of mem_data_rd1[32k+31:32k+8] over all k, evaluated per captured line.
//  FIFO behaviour:
//   First-word-fall-through; out_valid is registered.
//   Push and pop in the same cycle are allowed, and occupancy is unchanged.
//   Never full at push time, because ISSUE gates on room for the response.
//  busy=1 in ISSUE/WAIT/DRAIN.
//  Address arithmetic is 28-bit modulo; wrap is not checked.
//  start during busy: ignored.
//  rst mid-run: next edge forces the reset state and drops mem_valid_data1.
//   A pending DDR response after that is ignored.
//  out_ready=0 indefinitely: at most FIFO_DEPTH lines are fetched, then the block stalls in ISSUE with no request.
// TESTING
//  1. NUM_WORDS=4, ready 3 cycles after each valid, line k lane j = 32'h(k*8+j).
//     -> addrs 1000000,1000008,1000010,1000018; out_data k=0 is 64'h0706050403020100; done after 4 pops.
//  2. out_ready=0 for 50 cycles.
//     -> exactly FIFO_DEPTH requests issued, then mem_valid_data1 stays 0; on release, remaining lines follow in order.
//  3. One lane = 32'h0000_0155.
//     -> out byte 8'h55, fmt_err=1 and stays 1; cleared by the next start.
//  4. start pulsed while in WAIT.
//     -> ignored: address sequence and count unaffected.
//  5. rst asserted in WAIT, then mem_ready_data1 pulsed.
//     -> valid=0 and addr=1000000 next cycle; no FIFO push; done=0.
//  6. ready arrives in the same cycle as valid rises vs. after 10 cycles.
//     -> identical out_data stream; valid low at least 1 cycle between requests.

Source files
------------

// File: rtl/dcache_dummy_readback.sv
// dcache_dummy_readback
// Reads a run of image lines from DDR through the data-cache memory port,
// repacks the low byte of each 32-bit lane into a 64-bit pixel word and
// streams the words out through a small first-word-fall-through FIFO.
//
// Handshakes:
//  - DDR side: a request is held (mem_valid_data1=1, address stable) until
//    mem_ready_data1=1; read data is valid in that same cycle. Ready is only
//    looked at while a request is being held. Only one request is ever
//    outstanding, and valid drops for at least one cycle between requests.
//  - Consumer side: out_data is the FIFO head; a word is transferred on
//    every rising edge where out_valid=1 and out_ready=1.

// Small FWFT FIFO: head is visible while valid, valid is a register.
module dcache_dummy_readback_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  storage [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_next;
    logic          valid_q;
    logic          push_ok;
    logic          pop_ok;

    // A pop only takes effect when there is a head; a push only when there is room.
    assign pop_ok  = pop & valid_q;
    assign push_ok = push & (level_q != LW'(DEPTH));

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_q + LW'(1);
            2'b01:   level_next = level_q - LW'(1);
            default: level_next = level_q;
        endcase
    end

    // Pointers, occupancy and the registered valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            level_q <= level_next;
            valid_q <= (level_next != '0);
        end
    end

    // Data storage needs no reset: entries are only read while valid.
    always_ff @(posedge clk) begin
        if (push_ok) storage[wr_ptr] <= push_data;
    end

    // Head reads as zero when empty so the output is clean after reset.
    assign head  = valid_q ? storage[rd_ptr] : '0;
    assign valid = valid_q;
    assign level = level_q;
endmodule

module dcache_dummy_readback #(
    parameter logic [27:0] BASE_ADDR   = 28'h1000000,
    parameter int          NUM_WORDS   = 38400,
    parameter int          ADDR_STRIDE = 8,
    parameter int          FIFO_DEPTH  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         fmt_err,
    output logic [27:0]  mem_data_addr1,
    output logic         mem_rw_data1,
    output logic         mem_valid_data1,
    input  logic         mem_ready_data1,
    input  logic [255:0] mem_data_rd1,
    output logic [255:0] mem_data_wr1,
    output logic [63:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [27:0]   addr_q;
    logic [15:0]   line_cnt;
    logic [15:0]   line_cnt_inc;
    logic          fmt_err_q;

    logic          start_ok;
    logic          resp;
    logic          last_line;
    logic          room;

    logic [63:0]   packed_word;
    logic          lane_err;

    logic [LW-1:0] fifo_level;
    logic          fifo_valid;
    logic [63:0]   fifo_head;

    assign line_cnt_inc = line_cnt + 16'd1;
    assign last_line    = (line_cnt_inc == 16'(NUM_WORDS));
    assign room         = (fifo_level < LW'(FIFO_DEPTH));

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next      = state;
        start_ok        = 1'b0;
        resp            = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        mem_valid_data1 = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                // Only ask for a line once its response is sure to fit.
                if (room) state_next = S_WAIT;
            end
            S_WAIT: begin
                busy            = 1'b1;
                mem_valid_data1 = 1'b1;
                if (mem_ready_data1) begin
                    resp       = 1'b1;
                    state_next = last_line ? S_DRAIN : S_ISSUE;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (fifo_level == '0) state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Line address, line count and sticky format error for the current run.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= BASE_ADDR;
            line_cnt  <= '0;
            fmt_err_q <= 1'b0;
        end else if (start_ok) begin
            addr_q    <= BASE_ADDR;
            line_cnt  <= '0;
            fmt_err_q <= 1'b0;
        end else if (resp) begin
            addr_q   <= addr_q + 28'(ADDR_STRIDE);
            line_cnt <= line_cnt_inc;
            if (lane_err) fmt_err_q <= 1'b1;
        end
    end

    // Repack the low byte of each lane; any upper lane bit flags a bad line.
    always_comb begin
        packed_word = '0;
        lane_err    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            packed_word[8*k +: 8] = mem_data_rd1[32*k +: 8];
            lane_err              = lane_err | (|mem_data_rd1[32*k+8 +: 24]);
        end
    end

    dcache_dummy_readback_fifo #(
        .W     (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp),
        .push_data (packed_word),
        .pop       (out_ready),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .level     (fifo_level)
    );

    assign out_data       = fifo_head;
    assign out_valid      = fifo_valid;
    assign fmt_err        = fmt_err_q;
    assign mem_data_addr1 = addr_q;
    assign mem_rw_data1   = 1'b0;
    assign mem_data_wr1   = '0;
endmodule

// File: tb/tb_dcache_dummy_readback.sv
// Bench for dcache_dummy_readback: table-driven runs with fixed response
// latencies, hand-written corner sequences and randomized runs checked
// against a line-level reference model.
module tb_dcache_dummy_readback;
    localparam logic [27:0] BASE   = 28'h1000000;
    localparam int          NW     = 4;
    localparam int          STRIDE = 8;
    localparam int          DEPTH  = 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic         fmt_err;
    logic [27:0]  mem_data_addr1;
    logic         mem_rw_data1;
    logic         mem_valid_data1;
    logic         mem_ready_data1;
    logic [255:0] mem_data_rd1;
    logic [255:0] mem_data_wr1;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    dcache_dummy_readback #(
        .BASE_ADDR   (BASE),
        .NUM_WORDS   (NW),
        .ADDR_STRIDE (STRIDE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .fmt_err         (fmt_err),
        .mem_data_addr1  (mem_data_addr1),
        .mem_rw_data1    (mem_rw_data1),
        .mem_valid_data1 (mem_valid_data1),
        .mem_ready_data1 (mem_ready_data1),
        .mem_data_rd1    (mem_data_rd1),
        .mem_data_wr1    (mem_data_wr1),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_pack(input logic [255:0] l);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = l[32*k +: 8];
        return w;
    endfunction

    function automatic bit model_bad(input logic [255:0] l);
        bit b = 0;
        for (int k = 0; k < 8; k++) if (l[32*k+8 +: 24] != 24'h0) b = 1;
        return b;
    endfunction

    function automatic logic [255:0] mk_line(input logic [7:0] b0);
        logic [255:0] l = '0;
        for (int j = 0; j < 8; j++) l[32*j +: 32] = {24'h0, b0 + 8'(j)};
        return l;
    endfunction

    function automatic logic [255:0] mk_fill(input logic [7:0] b);
        logic [255:0] l = '0;
        for (int j = 0; j < 8; j++) l[32*j +: 32] = {24'h0, b};
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l = '0;
        for (int j = 0; j < 8; j++) begin
            l[32*j +: 8] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) l[32*j+8 +: 24] = 24'($urandom_range(1, 24'hFFFFFF));
        end
        return l;
    endfunction

    logic [63:0]  exp_q[$];
    logic [63:0]  got_q[$];
    logic [27:0]  addr_log[$];
    logic [255:0] line_q[$];
    int           req_idx = 0;
    int           pops = 0;
    bit           model_err = 0;

    // ---------------- DDR responder ----------------
    bit           resp_en = 1;
    int           lat_mode = 0;
    int           fixed_lat = 0;
    int           lat_max = 0;
    logic         resp_ready;
    logic [255:0] resp_data;
    logic         man_ready;
    logic [255:0] man_data;

    assign mem_ready_data1 = resp_en ? resp_ready : man_ready;
    assign mem_data_rd1    = resp_en ? resp_data  : man_data;

    initial begin : responder
        bit           in_req;
        bit           prev_valid;
        int           wait_cnt;
        int           cur_lat;
        logic [27:0]  cur_addr;
        logic [27:0]  ea;
        logic [255:0] rline;
        resp_ready = 1'b0;
        resp_data  = '0;
        in_req     = 0;
        prev_valid = 0;
        wait_cnt   = 0;
        cur_lat    = 0;
        cur_addr   = '0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                resp_ready = 1'b0;
                if (mem_valid_data1) begin
                    if (!in_req) begin
                        in_req   = 1;
                        wait_cnt = 0;
                        cur_lat  = (lat_mode != 0) ? int'($urandom_range(0, lat_max)) : fixed_lat;
                        chk("req_gap_prev_valid", 64'(prev_valid), 64'd0);
                        ea = BASE + 28'(req_idx * STRIDE);
                        chk("req_addr", 64'(mem_data_addr1), 64'(ea));
                        cur_addr = mem_data_addr1;
                        addr_log.push_back(mem_data_addr1);
                        req_idx++;
                    end else begin
                        chk("addr_stable", 64'(mem_data_addr1), 64'(cur_addr));
                    end
                    if (wait_cnt >= cur_lat) begin
                        rline = (line_q.size() != 0) ? line_q.pop_front() : rand_line();
                        resp_data  = rline;
                        resp_ready = 1'b1;
                        exp_q.push_back(model_pack(rline));
                        if (model_bad(rline)) model_err = 1;
                        in_req = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else if (in_req) begin
                    chk("valid_held_until_ready", 64'd0, 64'd1);
                    in_req = 0;
                end
            end else begin
                in_req = 0;
            end
            prev_valid = mem_valid_data1;
        end
    end

    // ---------------- consumer / scoreboard ----------------
    bit cons_en = 1;
    int cons_mode = 0;

    initial begin : consumer
        logic [63:0] e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = cons_en && (cons_mode == 0 || $urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                pops++;
                got_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start();
        @(negedge clk);
        req_idx   = 0;
        model_err = 0;
        pops      = 0;
        got_q.delete();
        addr_log.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_fmt_err_clear", 64'(fmt_err), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_done_low", 64'(done), 64'd0);
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (mem_valid_data1) seen = 1;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 64'(done), 64'd1);
    endtask

    task automatic end_run(input bit exp_err);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_req_count", 64'(req_idx), 64'(NW));
        chk("end_pops", 64'(pops), 64'(NW));
        chk("end_exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("end_fmt_err", 64'(fmt_err), 64'(exp_err));
        chk("end_valid_low", 64'(mem_valid_data1), 64'd0);
        chk("end_out_valid_low", 64'(out_valid), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [255:0] line;
        logic [27:0]  exp_addr;
        logic [63:0]  exp_word;
    } vec_t;

    vec_t tbl[16];
    int   lat_tbl[4];
    bit   err_tbl[4];

    // ---------------- main sequence ----------------
    initial begin : main
        logic [27:0]  addr_c[4];
        logic [63:0]  word_a[4];
        logic [255:0] tmp;
        bit           seen;

        addr_c = '{28'h1000000, 28'h1000008, 28'h1000010, 28'h1000018};
        word_a = '{64'h0706050403020100, 64'h0f0e0d0c0b0a0908,
                   64'h1716151413121110, 64'h1f1e1d1c1b1a1918};
        for (int i = 0; i < 4; i++) begin
            // runs 0, 2, 3: line k lane j = k*8+j
            tbl[i].line         = mk_line(8'(i * 8));
            tbl[i].exp_word     = word_a[i];
            tbl[8 + i].line     = mk_line(8'(i * 8));
            tbl[8 + i].exp_word = word_a[i];
            tbl[12 + i].line    = mk_line(8'(i * 8));
            tbl[12 + i].exp_word = word_a[i];
        end
        // run 1: lines carrying format errors in some lanes
        tbl[4].line = 256'h155;
        tbl[4].exp_word = 64'h0000000000000055;
        tbl[5].line = mk_fill(8'hAB);
        tbl[5].exp_word = 64'hABABABABABABABAB;
        tmp = '0;
        tmp[32*7 +: 32] = 32'hFF00_0012;
        tbl[6].line = tmp;
        tbl[6].exp_word = 64'h1200000000000000;
        tmp = '0;
        tmp[32*3 +: 32] = 32'h0000_0080;
        tbl[7].line = tmp;
        tbl[7].exp_word = 64'h0000000080000000;
        for (int i = 0; i < 16; i++) tbl[i].exp_addr = addr_c[i % 4];
        lat_tbl = '{3, 0, 0, 10};
        err_tbl = '{0, 1, 0, 0};

        man_ready = 1'b0;
        man_data  = '0;
        start     = 1'b0;
        rst       = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fmt_err", 64'(fmt_err), 64'd0);
        chk("rst_valid", 64'(mem_valid_data1), 64'd0);
        chk("rst_addr", 64'(mem_data_addr1), 64'(28'h1000000));
        chk("rst_rw", 64'(mem_rw_data1), 64'd0);
        chk("rst_wr_zero", 64'(|mem_data_wr1), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // table-driven runs: fixed latencies 3, 0, 0, 10 with an always-ready consumer
        cons_en = 1; cons_mode = 0; lat_mode = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) line_q.push_back(tbl[4*r + i].line);
            fixed_lat = lat_tbl[r];
            do_start();
            wait_done(400);
            end_run(err_tbl[r]);
            for (int i = 0; i < 4; i++) begin
                if (i < got_q.size()) chk("tbl_word", got_q[i], tbl[4*r + i].exp_word);
                else                  chk("tbl_word_missing", 64'd0, 64'd1);
                if (i < addr_log.size()) chk("tbl_addr", 64'(addr_log[i]), 64'(tbl[4*r + i].exp_addr));
                else                     chk("tbl_addr_missing", 64'd0, 64'd1);
            end
            repeat (5) @(negedge clk);
            chk("done_held", 64'(done), 64'd1);
            chk("fmt_err_held", 64'(fmt_err), 64'(err_tbl[r]));
        end

        // consumer stalled: only DEPTH lines fetched, then no request
        cons_en = 0; fixed_lat = 1;
        do_start();
        repeat (50) @(negedge clk);
        chk("stall_req_count", 64'(req_idx), 64'(DEPTH));
        chk("stall_valid_low", 64'(mem_valid_data1), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        cons_en = 1; cons_mode = 0;
        wait_done(400);
        end_run(model_err);

        // start pulsed while a request is pending
        lat_mode = 0; fixed_lat = 4;
        do_start();
        wait_valid(50, seen);
        chk("wait_seen_for_stray_start", 64'(seen), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        end_run(model_err);

        // reset while a request is pending, then a late response
        resp_en = 0;
        do_start();
        wait_valid(50, seen);
        chk("wait_seen_for_rst", 64'(seen), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 64'(mem_valid_data1), 64'd0);
        chk("midrst_addr", 64'(mem_data_addr1), 64'(28'h1000000));
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        man_ready = 1'b1;
        man_data  = {8{32'hDEAD_BE11}};
        @(negedge clk);
        man_ready = 1'b0;
        man_data  = '0;
        @(negedge clk);
        chk("late_resp_no_push", 64'(out_valid), 64'd0);
        chk("late_resp_no_err", 64'(fmt_err), 64'd0);
        chk("late_resp_idle", 64'(busy), 64'd0);
        chk("late_resp_done", 64'(done), 64'd0);
        resp_en = 1;
        @(negedge clk);

        // randomized runs against the model
        lat_mode = 1; cons_mode = 1;
        for (int r = 0; r < 20; r++) begin
            lat_max = $urandom_range(0, 6);
            do_start();
            if (r % 2 == 1) begin
                wait_valid(50, seen);
                if (seen) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            wait_done(2000);
            end_run(model_err);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
